// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter in front of a single-port RAM.
// Latency: request sampled in IDLE -> RAM access next cycle -> ack the cycle after (3-cycle slot).
// Backpressure: requesters hold reqN until ackN; a losing requester simply waits in IDLE arbitration.
//
// Ports:
//   clk, rst            - single clock, asynchronous active-high reset
//   reqN/weN/addrN/wdataN (N=0 CPU, N=1 loader/debug) - access request, sampled at grant
//   ackN, rdataN        - one-cycle completion pulse; read data held until next read completes
//   ram_cs/ram_we/ram_addr/ram_wdata/ram_rdata - RAM side, active only during ACCESS
//   busy, grant         - status: non-IDLE flag and one-hot owner of the current access
//   lock0/lock1         - present only when ARB_LOCK_EN is defined: winner may keep the RAM
//
// Optional feature macro: ARB_LOCK_EN

module ram_arbiter #(
    parameter int AW = 12,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
`ifdef ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_addr,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic [1:0]    grant
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;   // 0 = requester 0, 1 = requester 1
    logic          last_q,  last_d;    // requester served most recently
    logic          we_q,    we_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic elig0;
    logic elig1;
    logic pick1;

`ifdef ARB_LOCK_EN
    logic lock_q, lock_d;
    logic lock_hold;

    // The previous owner keeps exclusive rights only while its lock is still high in IDLE.
    assign lock_hold = lock_q & (owner_q ? lock1 : lock0);
    assign elig0     = req0 & ~(lock_hold & owner_q);
    assign elig1     = req1 & ~(lock_hold & ~owner_q);
`else
    assign elig0 = req0;
    assign elig1 = req1;
`endif

    // Requester 1 wins when it is the only candidate, or on a tie when requester 0 was served last.
    assign pick1 = elig1 & (~elig0 | ~last_q);

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
`ifdef ARB_LOCK_EN
        lock_d    = lock_q;
`endif
        ack0      = 1'b0;
        ack1      = 1'b0;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        busy      = 1'b1;
        grant     = owner_q ? 2'b10 : 2'b01;

        case (state_q)
            ST_IDLE: begin
                busy  = 1'b0;
                grant = 2'b00;
`ifdef ARB_LOCK_EN
                if (!lock_hold) begin
                    lock_d = 1'b0;
                end
`endif
                if (elig0 | elig1) begin
                    // Everything is captured here so later changes on the request side are ignored.
                    owner_d = pick1;
                    we_d    = pick1 ? we1    : we0;
                    addr_d  = pick1 ? addr1  : addr0;
                    wdata_d = pick1 ? wdata1 : wdata0;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                ram_cs    = 1'b1;
                ram_we    = we_q;
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                if (!we_q) begin
                    if (owner_q) begin
                        rdata1_d = ram_rdata;
                    end else begin
                        rdata0_d = ram_rdata;
                    end
                end
                state_d = ST_RESP;
            end

            ST_RESP: begin
                ack0   = ~owner_q;
                ack1   = owner_q;
                last_d = owner_q;
`ifdef ARB_LOCK_EN
                lock_d = owner_q ? lock1 : lock0;
`endif
                state_d = ST_IDLE;
            end

            default: begin
                busy    = 1'b0;
                grant   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;   // requester 0 wins the first tie after reset
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef ARB_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef ARB_LOCK_EN
            lock_q   <= lock_d;
`endif
        end
    end

    a_ack_onehot : assert property (@(posedge clk) disable iff (rst) !(ack0 && ack1));
    a_we_needs_cs : assert property (@(posedge clk) disable iff (rst) !(ram_we && !ram_cs));

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
    localparam int AW = 12;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic          ack0, ack1, ram_cs, ram_we, busy;
    logic [DW-1:0] rdata0, rdata1, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [1:0]    grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .grant(grant)
    );

    // RAM device: asynchronous read, write on the clock edge.
    logic [DW-1:0] mem [0:4095];
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A grant decided at edge g means: RAM access visible after edge g, ack after edge g+1,
    // next arbitration no earlier than edge g+3.
    int            cyc = 0, gcyc = 0;
    bit            have = 1'b0, who = 1'b0, last = 1'b1, m_we = 1'b0, m_lock = 1'b0;
    bit            e0, e1, acc, rsp;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0, m_rd0 = '0, m_rd1 = '0;
    logic [DW-1:0] mdl_mem [0:4095];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            have = 1'b0; last = 1'b1; m_lock = 1'b0; m_rd0 = '0; m_rd1 = '0;
        end else begin
            cyc++;
            if (have && cyc == gcyc + 1) begin
                if (m_we) mdl_mem[m_addr] = m_wd;
                else if (who) m_rd1 = mdl_mem[m_addr];
                else m_rd0 = mdl_mem[m_addr];
            end
            if (have && cyc == gcyc + 2) m_lock = who ? lock1 : lock0;
            if (!have || cyc >= gcyc + 3) begin
                if (m_lock && !(who ? lock1 : lock0)) m_lock = 1'b0;
                e0 = req0 && !(m_lock && who);
                e1 = req1 && !(m_lock && !who);
                if (e0 || e1) begin
                    who    = (e0 && e1) ? !last : e1;
                    last   = who;
                    m_we   = who ? we1 : we0;
                    m_addr = who ? addr1 : addr0;
                    m_wd   = who ? wdata1 : wdata0;
                    gcyc   = cyc;
                    have   = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        acc = have && (cyc == gcyc);
        rsp = have && (cyc == gcyc + 1);
        chk("busy",      busy,      acc || rsp);
        chk("grant",     grant,     (acc || rsp) ? (who ? 2'b10 : 2'b01) : 2'b00);
        chk("ack0",      ack0,      rsp && !who);
        chk("ack1",      ack1,      rsp && who);
        chk("ram_cs",    ram_cs,    acc);
        chk("ram_we",    ram_we,    acc && m_we);
        chk("ram_addr",  ram_addr,  acc ? m_addr : '0);
        chk("ram_wdata", ram_wdata, acc ? m_wd : '0);
        chk("rdata0",    rdata0,    m_rd0);
        chk("rdata1",    rdata1,    m_rd1);
        chk("ack_excl",  ack0 & ack1, 0);
        chk("we_wo_cs",  ram_we & ~ram_cs, 0);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [1:0] gq[$];
    logic [1:0] g_rr [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] g_lk [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
    int a0, a1, dbl;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = DW'((i * 7) % 16);
            mdl_mem[i] = DW'((i * 7) % 16);
        end
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_cs", ram_cs, 0);
        chk("rst_rdata0", rdata0, 0);
        step(); rst = 1'b0;

        // single write then read of 0x0A5 by requester 0
        req0 = 1; we0 = 1; addr0 = 12'h0A5; wdata0 = 4'h9;
        step(); req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        @(negedge clk);
        chk("wr_grant", grant, 2'b01);
        chk("wr_cs", ram_cs, 1);
        chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, 12'h0A5);
        chk("wr_data", ram_wdata, 4'h9);
        @(negedge clk);
        chk("wr_ack0", ack0, 1);
        step();
        req0 = 1; we0 = 0; addr0 = 12'h0A5;
        step(); req0 = 0; addr0 = '0;
        @(negedge clk);
        chk("rd_we", ram_we, 0);
        @(negedge clk);
        chk("rd_ack0", ack0, 1);
        chk("rd_rdata0", rdata0, 4'h9);

        // tie right after reset: requester 0 first, requester 1 three cycles later
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        req0 = 1; req1 = 1; addr0 = 12'h001; addr1 = 12'h002;
        step(); req0 = 0;
        @(negedge clk);
        chk("tie_grant0", grant, 2'b01);
        @(negedge clk);
        chk("tie_ack0", ack0, 1);
        chk("tie_rdata0", rdata0, 4'h7);
        step();
        @(negedge clk);
        chk("tie_idle_busy", busy, 0);
        step(); req1 = 0;
        @(negedge clk);
        chk("tie_grant1", grant, 2'b10);
        @(negedge clk);
        chk("tie_ack1", ack1, 1);
        chk("tie_rdata1", rdata1, 4'hE);

        // both held for 12 cycles: strict alternation
        step();
        req0 = 1; req1 = 1; addr0 = 12'h003; addr1 = 12'h004;
        a0 = 0; a1 = 0; dbl = 0; gq.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack0) a0++;
            if (ack1) a1++;
            if (ack0 && ack1) dbl++;
            if (ram_cs) gq.push_back(grant);
        end
        req0 = 0; req1 = 0;
        chk("rr_acks", a0 + a1, 4);
        chk("rr_ack0", a0, 2);
        chk("rr_double", dbl, 0);
        chk("rr_ngrants", gq.size(), 4);
        for (int i = 0; i < gq.size() && i < 4; i++) chk("rr_grant_seq", gq[i], g_rr[i]);

        // reset during ACCESS of a write to 0xFFF
        step();
        req1 = 1; we1 = 1; addr1 = 12'hFFF; wdata1 = 4'h5;
        step(); req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        #1;
        chk("ab_cs_before", ram_cs, 1);
        chk("ab_addr_before", ram_addr, 12'hFFF);
        rst = 1'b1;
        #1;
        chk("ab_cs", ram_cs, 0);
        chk("ab_we", ram_we, 0);
        chk("ab_addr", ram_addr, 0);
        chk("ab_wdata", ram_wdata, 0);
        chk("ab_busy", busy, 0);
        chk("ab_grant", grant, 0);
        chk("ab_ack", {ack1, ack0}, 0);
        chk("ab_rdata", {rdata1, rdata0}, 0);
        step(); rst = 1'b0;
        a0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack0 || ack1) a0++;
        end
        chk("ab_no_ack", a0, 0);
        chk("ab_idle", busy, 0);
        req0 = 1; we0 = 0; addr0 = 12'hFFF;
        step(); req0 = 0; addr0 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("ab_rd_ack0", ack0, 1);
        chk("ab_rd_fff", rdata0, 4'h9);

`ifdef ARB_LOCK_EN
        // lock1 held: requester 1 keeps the RAM until lock1 drops in IDLE
        step();
        lock1 = 1; req0 = 1; req1 = 1; addr0 = 12'h010; addr1 = 12'h011;
        gq.delete();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (ram_cs) gq.push_back(grant);
            if (i == 9) lock1 = 0;
        end
        req0 = 0; req1 = 0;
        chk("lk_ngrants", gq.size(), 4);
        for (int i = 0; i < gq.size() && i < 4; i++) chk("lk_grant_seq", gq[i], g_lk[i]);
`endif

        repeat (4) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
